id_ex_stage: RTL

- ID/EX pipeline stage of the RV32IM pipeline. It registers decoded instruction fields and drives the ALU operand and select inputs (ALU_DATA1, ALU_DATA2, ALU_SELECT) through a MEM/WB forwarding network.
- Detects load-use hazards and inserts bubbles.
- Holds multi-cycle M-extension ops (SELECT 01xxx) in EX for a fixed latency, asserting EX_BUSY to stall upstream.

---
 rtl/id_ex_stage_pkg.sv | 45 ++++
 rtl/id_ex_stage_fwd_mux.sv | 35 +++
 rtl/id_ex_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX stage.
// Holds ALU select encodings and the ID/EX register bundle.
package id_ex_stage_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b10000;
    localparam logic [4:0] ALU_FWD = 5'b11000;

    // SELECT[4:3] value marking the multi-cycle M-extension class
    localparam logic [1:0] MULDIV_CLASS = 2'b01;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [4:0]      alu_sel;
        logic            op1_pc;
        logic            op2_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } id_ex_t;

    function automatic logic is_muldiv(input logic [4:0] sel);
        return sel[4:3] == MULDIV_CLASS;
    endfunction

    // Writer hits a source register; x0 never matches
    function automatic logic reg_hit(
        input logic            we,
        input logic [REGW-1:0] rd,
        input logic [REGW-1:0] rs
    );
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// One-operand forwarding select: MEM result, then WB result,
// then the value held in the ID/EX register.
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [REGW-1:0] i_rs,
    input  logic [XLEN-1:0] i_stored,
    input  logic            i_mem_valid,
    input  logic            i_mem_reg_write,
    input  logic [REGW-1:0] i_mem_rd,
    input  logic [XLEN-1:0] i_mem_result,
    input  logic            i_wb_reg_write,
    input  logic [REGW-1:0] i_wb_rd,
    input  logic [XLEN-1:0] i_wb_result,
    output logic [XLEN-1:0] o_data
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = reg_hit(i_mem_valid && i_mem_reg_write,
                               i_mem_rd, i_rs);
    assign w_wb_hit  = reg_hit(i_wb_reg_write, i_wb_rd, i_rs);

    // Younger producer (MEM) takes priority over WB
    always_comb begin
        o_data = i_stored;
        if (w_mem_hit) begin
            o_data = i_mem_result;
        end else if (w_wb_hit) begin
            o_data = i_wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding,
// load-use bubble insertion and multi-cycle M-op occupancy.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ID_VALID,
    input  logic [XLEN-1:0] ID_PC,
    input  logic [XLEN-1:0] ID_RS1_DATA,
    input  logic [XLEN-1:0] ID_RS2_DATA,
    input  logic [XLEN-1:0] ID_IMM,
    input  logic [REGW-1:0] ID_RS1,
    input  logic [REGW-1:0] ID_RS2,
    input  logic [REGW-1:0] ID_RD,
    input  logic [4:0]      ID_ALU_SELECT,
    input  logic            ID_OP1_PC,
    input  logic            ID_OP2_IMM,
    input  logic            ID_REG_WRITE,
    input  logic            ID_MEM_READ,
    input  logic            ID_MEM_WRITE,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic            MEM_VALID,
    input  logic            MEM_REG_WRITE,
    input  logic [REGW-1:0] MEM_RD,
    input  logic [XLEN-1:0] MEM_RESULT,
    input  logic            WB_REG_WRITE,
    input  logic [REGW-1:0] WB_RD,
    input  logic [XLEN-1:0] WB_RESULT,
    output logic [XLEN-1:0] ALU_DATA1,
    output logic [XLEN-1:0] ALU_DATA2,
    output logic [4:0]      ALU_SELECT,
    output logic [XLEN-1:0] EX_STORE_DATA,
    output logic [XLEN-1:0] EX_PC,
    output logic [REGW-1:0] EX_RD,
    output logic            EX_VALID,
    output logic            EX_REG_WRITE,
    output logic            EX_MEM_READ,
    output logic            EX_MEM_WRITE,
    output logic            EX_BUSY,
    output logic            LOAD_USE_HAZARD
);

    localparam int CW = (MULDIV_LATENCY > 1) ? $clog2(MULDIV_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(MULDIV_LATENCY - 1);

    id_ex_t          r_ex;
    logic [CW-1:0]   r_count;

    id_ex_t          w_id;
    logic            w_ex_busy;
    logic            w_hazard;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    assign w_ex_busy = r_ex.valid && is_muldiv(r_ex.alu_sel)
                       && (r_count < LAST);

    assign w_hazard = r_ex.valid && r_ex.mem_read && (r_ex.rd != '0)
                      && ID_VALID
                      && ((ID_RS1 == r_ex.rd) || (ID_RS2 == r_ex.rd));

    // Bundle ID fields, applying WB write-through on read-during-write
    always_comb begin
        w_id           = '0;
        w_id.valid     = ID_VALID;
        w_id.pc        = ID_PC;
        w_id.rs1_data  = ID_RS1_DATA;
        w_id.rs2_data  = ID_RS2_DATA;
        w_id.imm       = ID_IMM;
        w_id.rs1       = ID_RS1;
        w_id.rs2       = ID_RS2;
        w_id.rd        = ID_RD;
        w_id.alu_sel   = ID_ALU_SELECT;
        w_id.op1_pc    = ID_OP1_PC;
        w_id.op2_imm   = ID_OP2_IMM;
        w_id.reg_write = ID_REG_WRITE;
        w_id.mem_read  = ID_MEM_READ;
        w_id.mem_write = ID_MEM_WRITE;
        if (reg_hit(WB_REG_WRITE, WB_RD, ID_RS1)) begin
            w_id.rs1_data = WB_RESULT;
        end
        if (reg_hit(WB_REG_WRITE, WB_RD, ID_RS2)) begin
            w_id.rs2_data = WB_RESULT;
        end
    end

    // EX register: reset > flush > hold > bubble > load
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ex    <= '0;
            r_count <= '0;
        end else if (FLUSH) begin
            r_ex.valid     <= 1'b0;
            r_ex.reg_write <= 1'b0;
            r_ex.mem_read  <= 1'b0;
            r_ex.mem_write <= 1'b0;
            r_count        <= '0;
        end else if (STALL || w_ex_busy) begin
            if (reg_hit(WB_REG_WRITE, WB_RD, r_ex.rs1)) begin
                r_ex.rs1_data <= WB_RESULT;
            end
            if (reg_hit(WB_REG_WRITE, WB_RD, r_ex.rs2)) begin
                r_ex.rs2_data <= WB_RESULT;
            end
            if (w_ex_busy && !STALL) begin
                r_count <= r_count + CW'(1);
            end
        end else if (w_hazard) begin
            r_ex.valid     <= 1'b0;
            r_ex.reg_write <= 1'b0;
            r_ex.mem_read  <= 1'b0;
            r_ex.mem_write <= 1'b0;
            r_count        <= '0;
        end else begin
            r_ex    <= w_id;
            r_count <= '0;
        end
    end

    fwd_mux u_fwd_rs1 (
        .i_rs            (r_ex.rs1),
        .i_stored        (r_ex.rs1_data),
        .i_mem_valid     (MEM_VALID),
        .i_mem_reg_write (MEM_REG_WRITE),
        .i_mem_rd        (MEM_RD),
        .i_mem_result    (MEM_RESULT),
        .i_wb_reg_write  (WB_REG_WRITE),
        .i_wb_rd         (WB_RD),
        .i_wb_result     (WB_RESULT),
        .o_data          (w_fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .i_rs            (r_ex.rs2),
        .i_stored        (r_ex.rs2_data),
        .i_mem_valid     (MEM_VALID),
        .i_mem_reg_write (MEM_REG_WRITE),
        .i_mem_rd        (MEM_RD),
        .i_mem_result    (MEM_RESULT),
        .i_wb_reg_write  (WB_REG_WRITE),
        .i_wb_rd         (WB_RD),
        .i_wb_result     (WB_RESULT),
        .o_data          (w_fwd_rs2)
    );

    assign ALU_DATA1       = r_ex.op1_pc  ? r_ex.pc  : w_fwd_rs1;
    assign ALU_DATA2       = r_ex.op2_imm ? r_ex.imm : w_fwd_rs2;
    assign ALU_SELECT      = r_ex.alu_sel;
    assign EX_STORE_DATA   = w_fwd_rs2;
    assign EX_PC           = r_ex.pc;
    assign EX_RD           = r_ex.rd;
    assign EX_VALID        = r_ex.valid;
    assign EX_REG_WRITE    = r_ex.reg_write;
    assign EX_MEM_READ     = r_ex.mem_read;
    assign EX_MEM_WRITE    = r_ex.mem_write;
    assign EX_BUSY         = w_ex_busy;
    assign LOAD_USE_HAZARD = w_hazard;

endmodule
